button_debouncer: RTL

//   Debounces one raw push-button/encoder input for the etch-a-sketch controls.

---
 rtl/button_debouncer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Debounces one raw push-button / encoder input. The raw input is brought into
// the clock domain by a two-flop synchronizer, then a four-state FSM commits a
// new level only after the synchronized input has held steady for BOUNCE_TICKS
// sample strobes. The sample strobe is the one-cycle "out" pulse of the
// upstream pulse_generator, so the debounce window is BOUNCE_TICKS times that
// generator's period.
//
// Parameters
//   N             width of the stability counter
//   BOUNCE_TICKS  consecutive stable ticks needed to commit (1 .. 2**N-1)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   ena            1 = FSM/counter advance, 0 = hold (synchronizer keeps running)
//   tick           one-cycle sample strobe
//   bouncy_in      raw asynchronous button input
//   debounced      committed clean level (registered)
//   positive_edge  one-cycle strobe when debounced goes 0->1 (registered)
//   negative_edge  one-cycle strobe when debounced goes 1->0 (registered)
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned N            = 8,
  parameter int unsigned BOUNCE_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic tick,
  input  logic bouncy_in,
  output logic debounced,
  output logic positive_edge,
  output logic negative_edge
);

  localparam logic [N-1:0] LAST_CNT = N'(BOUNCE_TICKS - 1);
  localparam logic [N-1:0] CNT_ONE  = N'(1);

  typedef enum logic [1:0] {
    S_LOW        = 2'd0,
    S_MAYBE_HIGH = 2'd1,
    S_HIGH       = 2'd2,
    S_MAYBE_LOW  = 2'd3
  } state_t;

  logic         s1_p0;
  logic         sync_p1;
  state_t       state;
  logic [N-1:0] cnt;

  // Stage 0/1: two-flop synchronizer; free-running, independent of ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_p0   <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      s1_p0   <= bouncy_in;
      sync_p1 <= s1_p0;
    end
  end

  // Stage 2: debounce FSM with registered level and edge strobes.
  // Strobes default low every cycle, which also forces them to 0 while ena=0.
  // A disagreeing sample always reverts a MAYBE state, even on a tick cycle,
  // and the cycle that enters a MAYBE state never counts its tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_LOW;
      cnt           <= '0;
      debounced     <= 1'b0;
      positive_edge <= 1'b0;
      negative_edge <= 1'b0;
    end else begin
      positive_edge <= 1'b0;
      negative_edge <= 1'b0;
      if (ena) begin
        case (state)
          S_LOW: begin
            if (sync_p1) begin
              state <= S_MAYBE_HIGH;
              cnt   <= '0;
            end
          end
          S_MAYBE_HIGH: begin
            if (!sync_p1) begin
              state <= S_LOW;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt == LAST_CNT) begin
                state         <= S_HIGH;
                cnt           <= '0;
                debounced     <= 1'b1;
                positive_edge <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          S_HIGH: begin
            if (!sync_p1) begin
              state <= S_MAYBE_LOW;
              cnt   <= '0;
            end
          end
          S_MAYBE_LOW: begin
            if (sync_p1) begin
              state <= S_HIGH;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt == LAST_CNT) begin
                state         <= S_LOW;
                cnt           <= '0;
                debounced     <= 1'b0;
                negative_edge <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          default: begin
            state     <= S_LOW;
            cnt       <= '0;
            debounced <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
